// File: rtl/reg_writeback_queue_pkg.sv
// Shared constants, FSM state encoding and the writeback entry layout for the
// register writeback queue.
package reg_writeback_queue_pkg;

  localparam int NUM_REGS = 2;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int IW       = $clog2(DEPTH);
  localparam int CW       = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// In-order circular buffer of writeback entries. Push/pop take effect at the clock
// edge; every live entry is exposed oldest-first for the forwarding search.
module wb_fifo
  import reg_writeback_queue_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  wb_entry_t             i_push_ent,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [CW-1:0]         o_count,
  output wb_entry_t [DEPTH-1:0] o_ents
);

  wb_entry_t     r_mem [DEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_tail;
  logic [IW-1:0] w_head_idx;

  assign w_head_idx = r_head[IW-1:0];
  assign o_count    = r_tail - r_head;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= r_tail;
    end else begin
      if (i_push) r_tail <= r_tail + CW'(1);
      if (i_pop)  r_head <= r_head + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail[IW-1:0]] <= i_push_ent;
  end

  // o_ents[0] is the head; slots at or beyond o_count hold stale data.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ents
    assign o_ents[k] = r_mem[w_head_idx + IW'(k)];
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register bank write port, one write per cycle, one
// cycle after acceptance; i_rf_hold stalls issue and a full queue or flush drops ready.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [AW-1:0]     i_wb_dest,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_flush,
  input  logic              i_rf_hold,
  output logic              o_reg_write,
  output logic [AW-1:0]     o_write_reg,
  output logic [DATA_W-1:0] o_write_data,
  output logic [NUM_REGS-1:0] o_pending,
  input  logic [AW-1:0]     i_fwd_addr,
  output logic              o_fwd_hit,
  output logic [DATA_W-1:0] o_fwd_data
);

  wb_state_t             r_state;
  logic                  r_reg_write;
  logic [AW-1:0]         r_write_reg;
  logic [DATA_W-1:0]     r_write_data;
  logic [CW-1:0]         r_pend [NUM_REGS];

  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_next_count;
  wb_entry_t             w_push_ent;
  wb_entry_t [DEPTH-1:0] w_ents;
  logic                  w_fwd_hit;
  logic [DATA_W-1:0]     w_fwd_data;

  assign o_wb_ready   = (w_count < CW'(DEPTH)) && !i_flush;
  assign w_push       = i_wb_valid && o_wb_ready;
  assign w_pop        = (r_state != IDLE) && !i_rf_hold && !i_flush;
  assign w_next_count = w_count + CW'(w_push) - CW'(w_pop);
  assign w_push_ent   = '{dest: i_wb_dest, data: i_wb_data};

  wb_fifo u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_ent (w_push_ent),
    .i_pop      (w_pop),
    .i_flush    (i_flush),
    .o_count    (w_count),
    .o_ents     (w_ents)
  );

  // Non-IDLE state tracks a non-empty FIFO, so issue needs no separate count compare.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_write_reg  <= w_ents[0].dest;
        r_write_data <= w_ents[0].data;
      end
      if (i_flush || (w_next_count == '0)) r_state <= IDLE;
      else if (i_rf_hold)                  r_state <= STALL;
      else                                 r_state <= ISSUE;
    end
  end

  // Flush: the write on the port retires at this same edge and no new issue
  // happens, so nothing remains outstanding afterwards.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        r_pend[i] <= r_pend[i] + CW'(w_push && (i_wb_dest == AW'(i)))
                               - CW'(r_reg_write && (r_write_reg == AW'(i)));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    assign o_pending[g] = (r_pend[g] != '0);
  end

  // Scan oldest to youngest so the youngest match ends up winning.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (r_reg_write && (r_write_reg == i_fwd_addr)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_write_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < w_count) && (w_ents[k].dest == i_fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_ents[k].data;
      end
    end
  end

  assign o_fwd_hit    = w_fwd_hit;
  assign o_fwd_data   = w_fwd_data;
  assign o_reg_write  = r_reg_write;
  assign o_write_reg  = r_write_reg;
  assign o_write_data = r_write_data;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wb_valid;
  logic                wb_ready;
  logic [AW-1:0]       wb_dest;
  logic [DATA_W-1:0]   wb_data;
  logic                flush;
  logic                rf_hold;
  logic                reg_write;
  logic [AW-1:0]       write_reg;
  logic [DATA_W-1:0]   write_data;
  logic [NUM_REGS-1:0] pending;
  logic [AW-1:0]       fwd_addr;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending writes in arrival order plus the write-port register.
  wb_entry_t         q[$];
  logic              m_rw;
  logic [AW-1:0]     m_wr;
  logic [DATA_W-1:0] m_wd;

  always #5 clk = ~clk;

  reg_writeback_queue dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_wb_valid   (wb_valid),
    .o_wb_ready   (wb_ready),
    .i_wb_dest    (wb_dest),
    .i_wb_data    (wb_data),
    .i_flush      (flush),
    .i_rf_hold    (rf_hold),
    .o_reg_write  (reg_write),
    .o_write_reg  (write_reg),
    .o_write_data (write_data),
    .o_pending    (pending),
    .i_fwd_addr   (fwd_addr),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_data   (fwd_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NUM_REGS-1:0] model_pending();
    logic [NUM_REGS-1:0] p = '0;
    foreach (q[j]) p[q[j].dest] = 1'b1;
    if (m_rw) p[m_wr] = 1'b1;
    return p;
  endfunction

  function automatic void model_fwd(input logic [AW-1:0] a, output logic hit,
                                    output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (m_rw && m_wr == a) begin hit = 1'b1; d = m_wd; end
    foreach (q[j]) if (q[j].dest == a) begin hit = 1'b1; d = q[j].data; end
  endfunction

  // Advance the model by one clock using the inputs currently applied, then
  // move to 1 time unit after the rising edge.
  task automatic step();
    logic push, pop;
    wb_entry_t e;
    if (!rst_n) begin
      q.delete();
      m_rw = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      push = wb_valid && (q.size() < DEPTH) && !flush;
      pop  = (q.size() > 0) && !rf_hold && !flush;
      if (pop) begin
        e = q.pop_front();
        m_rw = 1'b1; m_wr = e.dest; m_wd = e.data;
      end else begin
        m_rw = 1'b0;
      end
      if (flush) q.delete();
      if (push) q.push_back('{dest: wb_dest, data: wb_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] d, input logic [DATA_W-1:0] v);
    wb_valid = 1'b1; wb_dest = d; wb_data = v;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
    flush = 1'b0; rf_hold = 1'b0; fwd_addr = '0;
    step(); step();
    n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_reg_write got %0b exp 0", reg_write); end
    n_checks++; if (write_reg !== '0) begin n_errors++; $display("FAIL reset_write_reg got %0d exp 0", write_reg); end
    n_checks++; if (write_data !== '0) begin n_errors++; $display("FAIL reset_write_data got %0h exp 0", write_data); end
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL reset_pending got %b exp 0", pending); end
    n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin n_errors++; $display("FAIL reset_fwd got hit=%0b data=%0h exp 0/0", fwd_hit, fwd_data); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %0b exp 1", wb_ready); end
  endtask

  task automatic test_single();
    rf_hold = 1'b0;
    push_one(1, 8'h5A);
    #1;
    n_checks++; if (reg_write !== 1'b0 || pending[1] !== 1'b1) begin n_errors++; $display("FAIL single_queued got rw=%0b pend=%b exp rw=0 pend[1]=1", reg_write, pending); end
    step();
    n_checks++; if (reg_write !== 1'b1 || write_reg !== 1 || write_data !== 8'h5A) begin n_errors++; $display("FAIL single_write got rw=%0b reg=%0d data=%0h exp 1/1/5a", reg_write, write_reg, write_data); end
    n_checks++; if (pending[1] !== 1'b1) begin n_errors++; $display("FAIL single_pending_port got %b exp pending[1]=1", pending); end
    step();
    n_checks++; if (reg_write !== 1'b0 || pending !== '0) begin n_errors++; $display("FAIL single_retire got rw=%0b pend=%b exp 0/00", reg_write, pending); end
    n_checks++; if (write_data !== 8'h5A) begin n_errors++; $display("FAIL single_hold_data got %0h exp 5a", write_data); end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] vals [4];
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
    rf_hold = 1'b1;
    for (int k = 0; k < 4; k++) push_one(AW'(k % 2), vals[k]);
    #1;
    n_checks++; if (wb_ready !== 1'b0) begin n_errors++; $display("FAIL fill_full_ready got %0b exp 0", wb_ready); end
    n_checks++; if (pending !== 2'b11) begin n_errors++; $display("FAIL fill_pending got %b exp 11", pending); end
    rf_hold = 1'b0;
    step();
    n_checks++; if (wb_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready_after_pop got %0b exp 1", wb_ready); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_checks++;
      if (reg_write !== 1'b1 || write_reg !== AW'(k % 2) || write_data !== vals[k]) begin
        n_errors++;
        $display("FAIL fill_drain_%0d got rw=%0b reg=%0d data=%0h exp 1/%0d/%0h", k, reg_write, write_reg, write_data, k % 2, vals[k]);
      end
    end
    step();
    n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL fill_end got rw=%0b exp 0", reg_write); end
  endtask

  task automatic test_forward();
    rf_hold = 1'b1;
    push_one(0, 8'h11);
    push_one(0, 8'h22);
    fwd_addr = 0;
    #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h22) begin n_errors++; $display("FAIL fwd_youngest got hit=%0b data=%0h exp 1/22", fwd_hit, fwd_data); end
    fwd_addr = 1;
    #1;
    n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin n_errors++; $display("FAIL fwd_miss got hit=%0b data=%0h exp 0/0", fwd_hit, fwd_data); end
    rf_hold = 1'b0;
    fwd_addr = 0;
    step(); step();
    #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h22) begin n_errors++; $display("FAIL fwd_port got hit=%0b data=%0h exp 1/22", fwd_hit, fwd_data); end
    step();
  endtask

  task automatic test_hold_toggle();
    logic [DATA_W-1:0] vals [3];
    logic [AW-1:0]     dsts [3];
    int idx = 0;
    int rem = 3;
    int seen = 0;
    logic expect_w;
    vals[0] = 8'hC1; vals[1] = 8'hC2; vals[2] = 8'hC3;
    dsts[0] = 1;     dsts[1] = 0;     dsts[2] = 1;
    rf_hold = 1'b1;
    for (int k = 0; k < 3; k++) push_one(dsts[k], vals[k]);
    for (int c = 0; c < 8; c++) begin
      rf_hold = (c % 2 == 1);
      expect_w = !rf_hold && (rem > 0);
      step();
      if (reg_write === 1'b1) seen++;
      n_checks++;
      if (reg_write !== expect_w) begin n_errors++; $display("FAIL hold_toggle_rw_c%0d got %0b exp %0b", c, reg_write, expect_w); end
      if (expect_w) begin
        n_checks++;
        if (write_data !== vals[idx] || write_reg !== dsts[idx]) begin
          n_errors++;
          $display("FAIL hold_toggle_data_%0d got reg=%0d data=%0h exp %0d/%0h", idx, write_reg, write_data, dsts[idx], vals[idx]);
        end
        idx++; rem--;
      end
    end
    n_checks++; if (seen !== 3) begin n_errors++; $display("FAIL hold_toggle_count got %0d exp 3", seen); end
    rf_hold = 1'b0;
    step();
  endtask

  task automatic test_flush();
    int seen = 0;
    rf_hold = 1'b1;
    push_one(0, 8'h31);
    push_one(1, 8'h32);
    push_one(0, 8'h33);
    rf_hold = 1'b0;
    step();
    flush = 1'b1;
    wb_valid = 1'b1; wb_dest = 1; wb_data = 8'h99;
    #1;
    n_checks++; if (wb_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready got %0b exp 0", wb_ready); end
    n_checks++; if (reg_write !== 1'b1 || write_data !== 8'h31) begin n_errors++; $display("FAIL flush_inflight got rw=%0b data=%0h exp 1/31", reg_write, write_data); end
    n_checks++; if (pending !== 2'b11) begin n_errors++; $display("FAIL flush_pending_before got %b exp 11", pending); end
    step();
    flush = 1'b0; wb_valid = 1'b0;
    #1;
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL flush_pending_after got %b exp 00", pending); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL flush_fwd got hit=%0b exp 0", fwd_hit); end
    for (int c = 0; c < 5; c++) begin
      if (reg_write === 1'b1) seen++;
      step();
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL flush_leftover_writes got %0d exp 0", seen); end
  endtask

  task automatic test_random();
    logic              ehit;
    logic [DATA_W-1:0] edat;
    logic [NUM_REGS-1:0] epend;
    for (int c = 0; c < 400; c++) begin
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_dest  = AW'($urandom_range(0, NUM_REGS - 1));
      wb_data  = DATA_W'($urandom);
      rf_hold  = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      fwd_addr = AW'($urandom_range(0, NUM_REGS - 1));
      #1;
      model_fwd(fwd_addr, ehit, edat);
      epend = model_pending();
      n_checks++;
      if (wb_ready !== ((q.size() < DEPTH) && !flush)) begin
        n_errors++; $display("FAIL rand_ready c=%0d got %0b exp %0b", c, wb_ready, (q.size() < DEPTH) && !flush);
      end
      n_checks++;
      if (reg_write !== m_rw || write_reg !== m_wr || write_data !== m_wd) begin
        n_errors++; $display("FAIL rand_port c=%0d got %0b/%0d/%0h exp %0b/%0d/%0h", c, reg_write, write_reg, write_data, m_rw, m_wr, m_wd);
      end
      n_checks++;
      if (pending !== epend) begin
        n_errors++; $display("FAIL rand_pending c=%0d got %b exp %b", c, pending, epend);
      end
      n_checks++;
      if (fwd_hit !== ehit || fwd_data !== edat) begin
        n_errors++; $display("FAIL rand_fwd c=%0d got %0b/%0h exp %0b/%0h", c, fwd_hit, fwd_data, ehit, edat);
      end
      step();
    end
    wb_valid = 1'b0; rf_hold = 1'b0; flush = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) step();
  endtask

  task automatic test_async_reset();
    rf_hold = 1'b1;
    push_one(0, 8'h41);
    push_one(1, 8'h42);
    push_one(0, 8'h43);
    rf_hold = 1'b0;
    step(); step();
    n_checks++; if (reg_write !== 1'b1 || write_data !== 8'h42) begin n_errors++; $display("FAIL areset_pre got rw=%0b data=%0h exp 1/42", reg_write, write_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL areset_rw got %0b exp 0", reg_write); end
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL areset_pending got %b exp 00", pending); end
    n_checks++; if (write_data !== '0) begin n_errors++; $display("FAIL areset_data got %0h exp 0", write_data); end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (wb_ready !== 1'b1 || fwd_hit !== 1'b0) begin n_errors++; $display("FAIL areset_after got ready=%0b hit=%0b exp 1/0", wb_ready, fwd_hit); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL areset_lost_%0d got rw=%0b exp 0", c, reg_write); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_hold_toggle();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
